cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//  Shares the single common data bus (CDB) among N functional units: ALU, load/store, branch.
//  Each unit pushes one {rd_lock, result} pair per accepted handshake into its own one-entry holding slot.
//  A round-robin arbiter drains one slot per cycle onto a registered CDB.
//  The CDB feeds every reservation queue's lock-match/wake-up logic and the register-file unlock.
// PARAMETERS
//  N_REQ    3   number of requesting units (index 0 = ALU, 1 = LSU, 2 = BRU)
//  DATA_W   32  result width (= `Data_Width)
//  LOCK_W   5   rename-tag width (= `Reg_Lock_Width)
//  NO_LOCK  0   tag value meaning "no broadcast" (= `Reg_No_Lock)
// PORTS
//  clk         in   1              clock, rising edge
//  rst         in   1              reset: synchronous, active-high
//  flush       in   1              mispredict flush; drops all holding slots
//  req_valid   in   N_REQ          unit i presents a result
//  req_index   in   N_REQ*LOCK_W   tag of unit i, slice [i*LOCK_W +: LOCK_W]
//  req_result  in   N_REQ*DATA_W   data of unit i, slice [i*DATA_W +: DATA_W]
//  req_ready   out  N_REQ          slot i can accept this cycle
//  cdb_valid   out  1              CDB carries a broadcast this cycle
//  cdb_index   out  LOCK_W         broadcast tag; NO_LOCK when cdb_valid=0
//  cdb_result  out  DATA_W         broadcast data; 0 when cdb_valid=0
// BEHAVIOUR
//  Reset (rst=1 at the edge)
//   - all slots empty; rr_ptr=0
//   - cdb_valid=0, cdb_index=NO_LOCK, cdb_result=0
//   - rst overrides flush and req_valid
//  Handshake
//   - req_ready[i] = !slot_v[i] | grant[i]  (combinational, no dependence on req_valid)
//   - transfer when req_valid[i] & req_ready[i]; slot_v/slot_data load at that edge
//   - a granted slot may be refilled in the same cycle
//  Arbitration (combinational, within one cycle)
//   - candidates: slot_v
//   - grant goes to the first set bit scanning from rr_ptr upward, modulo N_REQ
//   - at most one grant per cycle
//   - on a grant to i: rr_ptr <= (i+1) mod N_REQ
//   - no grant: rr_ptr holds
//  CDB register
//   - granted slot is loaded into the CDB regs at the edge: cdb_valid=1, index/result from the slot
//   - else cdb_valid=0, cdb_index=NO_LOCK
//   - each broadcast lasts exactly one cycle
//  Latency
//   - accept at edge E; earliest broadcast visible in cycle E+1 .. E+2 (one cycle in slot, then CDB reg)
//   - no bypass from req_* to the CDB
//  Slot rules
//   - tag NO_LOCK is accepted but never broadcast; the slot is cleared without a grant
//   - an empty slot is not a candidate
//  Flush
//   - at the edge, all slot_v <= 0 and cdb_valid <= 0
//   - requests presented in a flush cycle are dropped even if req_ready=1
//   - rr_ptr is kept
//  Fairness
//   - with all N slots continuously refilled, each unit is granted exactly once per N cycles
//  Widths: results are passed through unmodified; no sign handling.
// STRUCTURE
//  - Shared defines file: CDB_N_REQ, CDB_REQ_ALU/LSU/BRU index constants; reuse
//    `Data_Width, `Reg_Lock_Width, `Reg_No_Lock.
//  - One sub-module, rr_pick #(N): inputs req[N], ptr; outputs onehot grant[N], any, idx.
//    Implemented as a double-width masked priority encode.
//  - Top holds slots, rr_ptr, CDB regs; no other state.
// TESTING
//  1. rst held 2 cycles with req_valid=3'b111 -> cdb_valid=0, cdb_index=0, req_ready=3'b111 after release.
//  2. Single ALU push: index=5, result=32'hDEAD_BEEF at edge E -> cdb_valid=1, index=5, result=DEADBEEF
//     in cycle E+2 only; the next cycle cdb_valid=0.
//  3. All three push at once (tags 1,2,3), rr_ptr=0 -> CDB order 1,2,3 on consecutive cycles;
//     req_ready=3'b000 for held slots.
//  4. Saturation: all units push every cycle for 12 cycles -> each tag source granted 4 times;
//     grant gaps are exactly 3 cycles.
//  5. flush asserted with slots 0 and 2 full and a new push on 1 -> next cycle cdb_valid=0,
//     all slots empty, no tag from any of the three ever broadcast.
//  6. Push with tag NO_LOCK on LSU alongside ALU tag 7 -> only tag 7 broadcast; LSU slot frees in one cycle.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the common-data-bus arbiter: unit indices, bus widths
// and the rename tag that means "nothing to broadcast".
package cdb_arbiter_pkg;

  localparam int CDB_N_REQ   = 3;
  localparam int CDB_REQ_ALU = 0;
  localparam int CDB_REQ_LSU = 1;
  localparam int CDB_REQ_BRU = 2;

  localparam int CDB_DATA_W  = 32;
  localparam int CDB_LOCK_W  = 5;
  localparam logic [CDB_LOCK_W-1:0] CDB_NO_LOCK = '0;

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Round-robin one-hot picker: the first set request at or above ptr, wrapping
// modulo N, found by a priority encode over a doubled request vector.
module rr_pick
  import cdb_arbiter_pkg::*;
#(
  parameter int N = CDB_N_REQ,
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic             any,
  output logic [PTR_W-1:0] idx
);

  logic [2*N-1:0] dbl;
  int             sel;

  always_comb begin
    dbl = {req, req};
    // Lower copy is masked below ptr; the upper copy supplies the wrap-around.
    for (int j = 0; j < N; j++) begin
      if (j < int'(ptr)) dbl[j] = 1'b0;
    end
    any = 1'b0;
    sel = 0;
    for (int j = 2*N-1; j >= 0; j--) begin
      if (dbl[j]) begin
        any = 1'b1;
        sel = (j >= N) ? j - N : j;
      end
    end
    idx = PTR_W'(sel);
    grant = '0;
    for (int k = 0; k < N; k++) begin
      grant[k] = any && (sel == k);
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding slot per functional unit, drained one
// per cycle in round-robin order onto a registered broadcast bus.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N_REQ  = CDB_N_REQ,
  parameter int DATA_W = CDB_DATA_W,
  parameter int LOCK_W = CDB_LOCK_W,
  parameter logic [LOCK_W-1:0] NO_LOCK = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*LOCK_W-1:0]  req_index,
  input  logic [N_REQ*DATA_W-1:0]  req_result,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     cdb_valid,
  output logic [LOCK_W-1:0]        cdb_index,
  output logic [DATA_W-1:0]        cdb_result
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  function automatic logic [PTR_W-1:0] rr_next(input logic [PTR_W-1:0] i);
    return (int'(i) == N_REQ - 1) ? '0 : i + PTR_W'(1);
  endfunction

  logic [N_REQ-1:0]  slot_vld_p0;
  logic [LOCK_W-1:0] slot_tag_p0  [N_REQ];
  logic [DATA_W-1:0] slot_data_p0 [N_REQ];
  logic [PTR_W-1:0]  rr_ptr;

  logic [N_REQ-1:0]  cand;
  logic [N_REQ-1:0]  drop;
  logic [N_REQ-1:0]  grant;
  logic [N_REQ-1:0]  accept;
  logic              gnt_any;
  logic [PTR_W-1:0]  gnt_idx;
  logic [LOCK_W-1:0] gnt_tag;
  logic [DATA_W-1:0] gnt_data;

  logic              cdb_vld_p1;
  logic [LOCK_W-1:0] cdb_tag_p1;
  logic [DATA_W-1:0] cdb_data_p1;

  // A slot holding NO_LOCK never competes; it is simply emptied.
  always_comb begin
    cand = '0;
    drop = '0;
    for (int i = 0; i < N_REQ; i++) begin
      drop[i] = slot_vld_p0[i] && (slot_tag_p0[i] == NO_LOCK);
      cand[i] = slot_vld_p0[i] && !drop[i];
    end
  end

  rr_pick #(.N(N_REQ)) u_pick (
    .req   (cand),
    .ptr   (rr_ptr),
    .grant (grant),
    .any   (gnt_any),
    .idx   (gnt_idx)
  );

  always_comb begin
    gnt_tag  = '0;
    gnt_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        gnt_tag  = gnt_tag  | slot_tag_p0[i];
        gnt_data = gnt_data | slot_data_p0[i];
      end
    end
  end

  assign req_ready = ~slot_vld_p0 | grant;
  assign accept    = req_valid & req_ready;

  // ---- stage p0: per-unit holding slots ----
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      slot_vld_p0 <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (accept[i])                slot_vld_p0[i] <= 1'b1;
        else if (grant[i] || drop[i]) slot_vld_p0[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (accept[i]) begin
        slot_tag_p0[i]  <= req_index[i*LOCK_W +: LOCK_W];
        slot_data_p0[i] <= req_result[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                    rr_ptr <= '0;
    else if (!flush && gnt_any) rr_ptr <= rr_next(gnt_idx);
  end

  // ---- stage p1: registered broadcast, idle value is NO_LOCK / zero ----
  always_ff @(posedge clk) begin
    if (rst || flush || !gnt_any) begin
      cdb_vld_p1  <= 1'b0;
      cdb_tag_p1  <= NO_LOCK;
      cdb_data_p1 <= '0;
    end else begin
      cdb_vld_p1  <= 1'b1;
      cdb_tag_p1  <= gnt_tag;
      cdb_data_p1 <= gnt_data;
    end
  end

  assign cdb_valid  = cdb_vld_p1;
  assign cdb_index  = cdb_tag_p1;
  assign cdb_result = cdb_data_p1;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: expected broadcasts are queued when stimulus is
// driven and popped by a CDB monitor; table vectors plus timed sequences.
module tb_cdb_arbiter;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [2:0]  req_valid;
  logic [14:0] req_index;
  logic [95:0] req_result;
  logic [2:0]  req_ready;
  logic        cdb_valid;
  logic [4:0]  cdb_index;
  logic [31:0] cdb_result;

  cdb_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_index  (req_index),
    .req_result (req_result),
    .req_ready  (req_ready),
    .cdb_valid  (cdb_valid),
    .cdb_index  (cdb_index),
    .cdb_result (cdb_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  tag;
    logic [31:0] res;
  } exp_t;

  typedef struct {
    logic [2:0]       mask;
    logic [2:0][4:0]  tag;
    logic [2:0][31:0] res;
    int               n;
    logic [2:0][1:0]  ord;
  } vec_t;

  exp_t sb_q[$];
  exp_t mon_e;
  vec_t vecs[7];
  vec_t v5b;
  int   checks;
  int   failures;
  bit   mon_en;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (cdb_valid) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL cdb_unexpected: got tag %0h result %0h expected no broadcast",
                   cdb_index, cdb_result);
        end else begin
          mon_e = sb_q.pop_front();
          check("cdb_tag", 64'(cdb_index), 64'(mon_e.tag));
          check("cdb_result", 64'(cdb_result), 64'(mon_e.res));
        end
      end else begin
        check("cdb_idle_index", 64'(cdb_index), 64'(0));
        check("cdb_idle_result", 64'(cdb_result), 64'(0));
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    mon_en    = 1'b0;
    rst       = 1'b1;
    flush     = 1'b0;
    req_valid = 3'b111;
    repeat (2) @(negedge clk);
    rst       = 1'b0;
    req_valid = 3'b000;
    sb_q.delete();
    mon_en    = 1'b1;
  endtask

  task automatic apply_vec(input string name, input vec_t v);
    @(negedge clk);
    req_valid  = v.mask;
    req_index  = v.tag;
    req_result = v.res;
    for (int j = 0; j < v.n; j++) begin
      sb_q.push_back('{tag: v.tag[v.ord[j]], res: v.res[v.ord[j]]});
    end
    @(negedge clk);
    req_valid = 3'b000;
    repeat (5) @(negedge clk);
    check({name, "_ready"}, 64'(req_ready), 64'(3'b111));
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    mon_en     = 1'b0;
    rst        = 1'b1;
    flush      = 1'b0;
    req_valid  = '0;
    req_index  = '0;
    req_result = '0;

    // ord lists source indices in expected broadcast order (entry 0 first)
    vecs[0] = '{3'b111, {5'd13, 5'd12, 5'd11}, {32'h0000_0013, 32'h0000_0012, 32'h0000_0011},
                3, {2'd0, 2'd2, 2'd1}};
    vecs[1] = '{3'b101, {5'd15, 5'd0, 5'd14}, {32'hCAFE_0015, 32'h0, 32'hCAFE_0014},
                2, {2'd0, 2'd0, 2'd2}};
    vecs[2] = '{3'b010, {5'd0, 5'd16, 5'd0}, {32'h0, 32'h1234_5678, 32'h0},
                1, {2'd0, 2'd0, 2'd1}};
    vecs[3] = '{3'b011, {5'd0, 5'd18, 5'd17}, {32'h0, 32'hA5A5_A5A5, 32'h5A5A_5A5A},
                2, {2'd0, 2'd1, 2'd0}};
    vecs[4] = '{3'b110, {5'd20, 5'd19, 5'd0}, {32'h0000_0020, 32'h0000_0019, 32'h0},
                2, {2'd0, 2'd1, 2'd2}};
    vecs[5] = '{3'b111, {5'd23, 5'd22, 5'd21}, {32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000},
                3, {2'd1, 2'd0, 2'd2}};
    vecs[6] = '{3'b111, {5'd25, 5'd0, 5'd24}, {32'h0000_0025, 32'hBAD0_BAD0, 32'h0000_0024},
                2, {2'd0, 2'd0, 2'd2}};
    v5b     = '{3'b111, {5'd31, 5'd30, 5'd29}, {32'h0000_0031, 32'h0000_0030, 32'h0000_0029},
                3, {2'd1, 2'd0, 2'd2}};

    // Reset held two cycles with every unit requesting
    do_reset();
    check("rst_cdb_valid", 64'(cdb_valid), 64'(0));
    check("rst_cdb_index", 64'(cdb_index), 64'(0));
    check("rst_cdb_result", 64'(cdb_result), 64'(0));
    check("rst_ready", 64'(req_ready), 64'(3'b111));

    // Single ALU push: broadcast exactly two cycles after the accepting edge
    @(negedge clk);
    req_valid  = 3'b001;
    req_index  = {5'd0, 5'd0, 5'd5};
    req_result = {32'h0, 32'h0, 32'hDEAD_BEEF};
    sb_q.push_back('{tag: 5'd5, res: 32'hDEAD_BEEF});
    @(negedge clk);
    req_valid = 3'b000;
    check("single_e1_valid", 64'(cdb_valid), 64'(0));
    @(negedge clk);
    check("single_e2_valid", 64'(cdb_valid), 64'(1));
    check("single_e2_index", 64'(cdb_index), 64'(5));
    @(negedge clk);
    check("single_e3_valid", 64'(cdb_valid), 64'(0));
    repeat (2) @(negedge clk);

    // Three simultaneous pushes from rr_ptr = 0
    do_reset();
    @(negedge clk);
    req_valid  = 3'b111;
    req_index  = {5'd3, 5'd2, 5'd1};
    req_result = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    sb_q.push_back('{tag: 5'd1, res: 32'h1111_1111});
    sb_q.push_back('{tag: 5'd2, res: 32'h2222_2222});
    sb_q.push_back('{tag: 5'd3, res: 32'h3333_3333});
    @(negedge clk);
    req_valid = 3'b000;
    check("three_e1_ready", 64'(req_ready), 64'(3'b001));
    check("three_e1_valid", 64'(cdb_valid), 64'(0));
    @(negedge clk);
    check("three_e2_index", 64'(cdb_index), 64'(1));
    check("three_e2_ready", 64'(req_ready), 64'(3'b011));
    @(negedge clk);
    check("three_e3_index", 64'(cdb_index), 64'(2));
    check("three_e3_ready", 64'(req_ready), 64'(3'b111));
    @(negedge clk);
    check("three_e4_index", 64'(cdb_index), 64'(3));
    @(negedge clk);
    check("three_e5_valid", 64'(cdb_valid), 64'(0));
    repeat (2) @(negedge clk);

    // Saturation: every unit requests for 12 cycles; tags 8/9/10 identify the unit
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k >= 2 && k < 14) begin
        check("sat_valid", 64'(cdb_valid), 64'(1));
        check("sat_rotation", 64'(cdb_index), 64'(8 + ((k - 2) % 3)));
      end
      if (k < 12) begin
        req_valid  = 3'b111;
        req_index  = {5'd10, 5'd9, 5'd8};
        req_result = {32'(k * 16 + 2), 32'(k * 16 + 1), 32'(k * 16)};
        for (int i = 0; i < 3; i++) begin
          if (req_ready[i]) sb_q.push_back('{tag: 5'(8 + i), res: 32'(k * 16 + i)});
        end
      end else begin
        req_valid = 3'b000;
      end
    end
    repeat (3) @(negedge clk);

    // Flush with slots 0 and 2 full and a fresh push on unit 1
    @(negedge clk);
    req_valid  = 3'b101;
    req_index  = {5'd27, 5'd0, 5'd26};
    req_result = {32'h0000_0027, 32'h0, 32'h0000_0026};
    @(negedge clk);
    flush      = 1'b1;
    req_valid  = 3'b010;
    req_index  = {5'd0, 5'd28, 5'd0};
    req_result = {32'h0, 32'h0000_0028, 32'h0};
    check("flush_push_ready", 64'(req_ready[1]), 64'(1));
    @(negedge clk);
    flush     = 1'b0;
    req_valid = 3'b000;
    check("flush_cdb_valid", 64'(cdb_valid), 64'(0));
    check("flush_slots_empty", 64'(req_ready), 64'(3'b111));
    repeat (4) @(negedge clk);

    // Pointer survives the flush: scan resumes at unit 2
    apply_vec("post_flush", v5b);

    // NO_LOCK on LSU next to ALU tag 7
    @(negedge clk);
    req_valid  = 3'b011;
    req_index  = {5'd0, 5'd0, 5'd7};
    req_result = {32'h0, 32'h0000_0055, 32'h0000_0077};
    sb_q.push_back('{tag: 5'd7, res: 32'h0000_0077});
    @(negedge clk);
    req_valid = 3'b000;
    check("nolock_e1_ready", 64'(req_ready), 64'(3'b101));
    @(negedge clk);
    check("nolock_e2_ready", 64'(req_ready), 64'(3'b111));
    check("nolock_e2_valid", 64'(cdb_valid), 64'(1));
    check("nolock_e2_index", 64'(cdb_index), 64'(7));
    repeat (3) @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      apply_vec($sformatf("vec%0d", v), vecs[v]);
    end

    repeat (2) @(negedge clk);
    check("sb_drained", 64'(sb_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
